cond_logic: RTL and testbench

Condition-and-flags unit for the multicycle ARM datapath. Sits directly downstream of the ALU and consumes its 4-bit NZCV flag vector. Holds the architectural flags, evaluates the instruction's 4-bit condition field at decode, and latches the pass/fail result for the rest of the instruction. Uses that latched result to gate PC, register-file and memory write enables from the main decoder.

---
 rtl/cond_logic.sv | 106 ++++++++++
 tb/tb_cond_logic.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Condition-and-flags unit: holds NZCV, evaluates the condition field at decode, gates write enables.
// Latency: Cond->CondEx and ALUFlags->Flags take 1 cycle; CondEx->write enables are combinational.
// Backpressure: Stall freezes Flags and CondEx; write-enable gating ignores Stall (the FSM drops requests).
module cond_logic (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       InstrValid,
  input  logic       Stall,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_pass;

  // Individual flag bits of the architectural register (never the live ALU flags).
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Evaluate the condition field against the registered flags; NV decodes to never.
  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = ~flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = ~flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = ~flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = ~flag_v;
      COND_HI: cond_pass = flag_c & ~flag_z;
      COND_LS: cond_pass = ~flag_c | flag_z;
      COND_GE: cond_pass = (flag_n == flag_v);
      COND_LT: cond_pass = (flag_n != flag_v);
      COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_pass = flag_z | (flag_n != flag_v);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  // Next-state: flag write is qualified by the pre-edge CondEx, new CondEx uses pre-edge flags.
  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (!Stall) begin
      if (condex_q && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (condex_q && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
      if (InstrValid)           condex_d     = cond_pass;
    end
  end

  // State registers; synchronous reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  assign Flags    = flags_q;
  assign CondEx   = condex_q;
  assign PCWrite  = (PCS & condex_q) | NextPC;
  assign RegWrite = RegW & condex_q & ~NoWrite;
  assign MemWrite = MemW & condex_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, condition sweep, partial flag writes, gating, stall.
// Latency: inputs driven 1ns after the rising edge, registered results checked after the next edge.
// Backpressure: Stall is exercised explicitly; no waits on DUT events, so the run always ends.
module tb_cond_logic;

  logic       clk;
  logic       reset_n;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       InstrValid;
  logic       Stall;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic [3:0] Flags;
  logic       CondEx;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;

  int tests_run;
  int tests_failed;

  cond_logic dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Cond      (Cond),
    .ALUFlags  (ALUFlags),
    .InstrValid(InstrValid),
    .Stall     (Stall),
    .FlagW     (FlagW),
    .PCS       (PCS),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .NoWrite   (NoWrite),
    .Flags     (Flags),
    .CondEx    (CondEx),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARM-style reference: pairs of codes share a base test, odd code inverts it.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n ~^ v);
      3'd6: base = !z && (n ~^ v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    if (c == 4'b1110) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Cond = 4'b1110; ALUFlags = 4'b0000; InstrValid = 1'b0; Stall = 1'b0;
    FlagW = 2'b00; PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
  endtask

  // Decode an AL instruction so CondEx=1, then write all flags to f.
  task automatic load_flags(input logic [3:0] f);
    idle_inputs();
    InstrValid = 1'b1; Cond = 4'b1110;
    tick();
    idle_inputs();
    FlagW = 2'b11; ALUFlags = f;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0; ALUFlags = 4'hF; FlagW = 2'b11; InstrValid = 1'b1;
    tick();
    tick();
    RegW = 1'b1; NextPC = 1'b1; MemW = 1'b1;
    #1;
    tests_run++;
    if (Flags !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags got %b want 0000", Flags); end
    tests_run++;
    if (CondEx !== 1'b0) begin tests_failed++; $display("FAIL reset_condex got %b want 0", CondEx); end
    tests_run++;
    if (RegWrite !== 1'b0) begin tests_failed++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    tests_run++;
    if (PCWrite !== 1'b1) begin tests_failed++; $display("FAIL reset_pcwrite got %b want 1", PCWrite); end
    tests_run++;
    if (MemWrite !== 1'b0) begin tests_failed++; $display("FAIL reset_memwrite got %b want 0", MemWrite); end
    // Reset mid-instruction: CondEx=1 then reset blocks pending writes.
    reset_n = 1'b1;
    idle_inputs();
    InstrValid = 1'b1;
    tick();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    RegW = 1'b1; MemW = 1'b1;
    #1;
    tests_run++;
    if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      tests_failed++; $display("FAIL reset_midinstr got reg=%b mem=%b want 0 0", RegWrite, MemWrite);
    end
    idle_inputs();
  endtask

  task automatic test_cond_sweep();
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      tests_run++;
      if (Flags !== 4'(f)) begin tests_failed++; $display("FAIL sweep_load got %b want %b", Flags, 4'(f)); end
      for (int c = 0; c < 16; c++) begin
        InstrValid = 1'b1; Cond = 4'(c);
        tick();
        tests_run++;
        if (CondEx !== ref_cond(4'(c), 4'(f))) begin
          tests_failed++;
          $display("FAIL sweep_cond flags=%b cond=%b got %b want %b", 4'(f), 4'(c), CondEx, ref_cond(4'(c), 4'(f)));
        end
      end
      idle_inputs();
    end
    // Hand-computed spot checks with Flags=0100.
    load_flags(4'b0100);
    InstrValid = 1'b1; Cond = 4'b0000; tick();
    tests_run++;
    if (CondEx !== 1'b1) begin tests_failed++; $display("FAIL spot_eq got %b want 1", CondEx); end
    Cond = 4'b1100; tick();
    tests_run++;
    if (CondEx !== 1'b0) begin tests_failed++; $display("FAIL spot_gt got %b want 0", CondEx); end
    Cond = 4'b1111; tick();
    tests_run++;
    if (CondEx !== 1'b0) begin tests_failed++; $display("FAIL spot_nv got %b want 0", CondEx); end
    idle_inputs();
  endtask

  task automatic test_partial_flags();
    load_flags(4'b0000);
    tests_run++;
    if (Flags !== 4'b0000 || CondEx !== 1'b1) begin
      tests_failed++; $display("FAIL partial_setup got flags=%b condex=%b want 0000 1", Flags, CondEx);
    end
    ALUFlags = 4'b1111; FlagW = 2'b10; tick();
    tests_run++;
    if (Flags !== 4'b1100) begin tests_failed++; $display("FAIL partial_nz got %b want 1100", Flags); end
    ALUFlags = 4'b0010; FlagW = 2'b01; tick();
    tests_run++;
    if (Flags !== 4'b1110) begin tests_failed++; $display("FAIL partial_cv got %b want 1110", Flags); end
    idle_inputs();
  endtask

  task automatic test_failed_cond();
    load_flags(4'b0000);
    InstrValid = 1'b1; Cond = 4'b0000; tick();
    idle_inputs();
    tests_run++;
    if (CondEx !== 1'b0) begin tests_failed++; $display("FAIL failcond_condex got %b want 0", CondEx); end
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'hF;
    #1;
    tests_run++;
    if ({RegWrite, MemWrite, PCWrite} !== 3'b000) begin
      tests_failed++; $display("FAIL failcond_gating got reg/mem/pc=%b want 000", {RegWrite, MemWrite, PCWrite});
    end
    tick();
    tests_run++;
    if (Flags !== 4'b0000) begin tests_failed++; $display("FAIL failcond_flags got %b want 0000", Flags); end
    idle_inputs();
  endtask

  task automatic test_cmp();
    load_flags(4'b0000);
    RegW = 1'b1; NoWrite = 1'b0; MemW = 1'b1; PCS = 1'b1;
    #1;
    tests_run++;
    if ({RegWrite, MemWrite, PCWrite} !== 3'b111) begin
      tests_failed++; $display("FAIL pass_gating got reg/mem/pc=%b want 111", {RegWrite, MemWrite, PCWrite});
    end
    MemW = 1'b0; PCS = 1'b0;
    NoWrite = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0110;
    #1;
    tests_run++;
    if (RegWrite !== 1'b0) begin tests_failed++; $display("FAIL cmp_regwrite got %b want 0", RegWrite); end
    tick();
    tests_run++;
    if (Flags !== 4'b0110) begin tests_failed++; $display("FAIL cmp_flags got %b want 0110", Flags); end
    idle_inputs();
  endtask

  task automatic test_stall_simul();
    load_flags(4'b0000);
    Stall = 1'b1; InstrValid = 1'b1; Cond = 4'b1111; FlagW = 2'b11; ALUFlags = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (Flags !== 4'b0000 || CondEx !== 1'b1) begin
        tests_failed++; $display("FAIL stall_hold cyc=%0d got flags=%b condex=%b want 0000 1", i, Flags, CondEx);
      end
    end
    Stall = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0100; InstrValid = 1'b1; Cond = 4'b0000;
    tick();
    tests_run++;
    if (Flags !== 4'b0100 || CondEx !== 1'b0) begin
      tests_failed++; $display("FAIL simul got flags=%b condex=%b want 0100 0", Flags, CondEx);
    end
  endtask

  task automatic test_back_to_back();
    // Pre-edge CondEx=0 blocks the flag write; decode sees the Z=1 just written.
    FlagW = 2'b11; ALUFlags = 4'b0000; InstrValid = 1'b1; Cond = 4'b0000;
    tick();
    tests_run++;
    if (Flags !== 4'b0100 || CondEx !== 1'b1) begin
      tests_failed++; $display("FAIL b2b got flags=%b condex=%b want 0100 1", Flags, CondEx);
    end
    idle_inputs();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_cond_sweep();
    test_partial_flags();
    test_failed_cond();
    test_cmp();
    test_stall_simul();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
